// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel programmable clock divider.
package clk_div_pkg;

    // Reset values for period (P) and high-time (H): 1 Hz at 50% duty from a 50 MHz board clock.
    localparam logic [31:0] DEF_PERIOD = 32'd49_999_999;
    localparam logic [31:0] DEF_HIGH   = 32'd25_000_000;

    // Width of a channel-select field, never narrower than one bit.
    function automatic int ch_sel_w(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, enable flop, active/shadow configuration and output decode.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RST_PERIOD = WIDTH'(DEF_PERIOD),
    parameter logic [WIDTH-1:0] RST_HIGH   = WIDTH'(DEF_HIGH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_period,
    input  logic [WIDTH-1:0] wr_high,
    output logic             div_out,
    output logic             tick,
    output logic             pending
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             en_q_q, en_q_d;
    logic [WIDTH-1:0] p_act_q, p_act_d, h_act_q, h_act_d;
    logic [WIDTH-1:0] p_sh_q, p_sh_d, h_sh_q, h_sh_d;
    logic             pend_q, pend_d;
    logic             restart;

    // A sync pulse and the natural end of period are the same event: one restart.
    assign restart = en_q_q && (sync || (cnt_q == p_act_q));

    // NOTE: every signal gets its hold value first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        en_q_d  = en;
        cnt_d   = '0;
        p_act_d = p_act_q;
        h_act_d = h_act_q;
        p_sh_d  = p_sh_q;
        h_sh_d  = h_sh_q;
        pend_d  = pend_q;

        if (en && en_q_q && !restart) begin
            cnt_d = cnt_q + WIDTH'(1);
        end

        if (restart && pend_q) begin
            p_act_d = p_sh_q;
            h_act_d = h_sh_q;
            pend_d  = 1'b0;
        end

        // An idle channel or one at a period boundary can take new values without a glitch.
        if (wr) begin
            p_sh_d = wr_period;
            h_sh_d = wr_high;
            if (!en_q_q || restart) begin
                p_act_d = wr_period;
                h_act_d = wr_high;
                pend_d  = 1'b0;
            end else begin
                pend_d  = 1'b1;
            end
        end
    end

    // NOTE: configuration registers are reset too, so a mid-period reset always returns to known defaults.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            en_q_q  <= 1'b0;
            p_act_q <= RST_PERIOD;
            h_act_q <= RST_HIGH;
            p_sh_q  <= RST_PERIOD;
            h_sh_q  <= RST_HIGH;
            pend_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            cnt_q   <= cnt_d;
            en_q_q  <= en_q_d;
            p_act_q <= p_act_d;
            h_act_q <= h_act_d;
            p_sh_q  <= p_sh_d;
            h_sh_q  <= h_sh_d;
            pend_q  <= pend_d;
        end
    end

    assign div_out = en_q_q && (cnt_q < h_act_q);
    assign tick    = en_q_q && (cnt_q == p_act_q);
    assign pending = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers sharing one config port and one sync input.
module clk_div_bank #(
    parameter int               CH         = 4,
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] DEF_PERIOD = WIDTH'(clk_div_pkg::DEF_PERIOD),
    parameter logic [WIDTH-1:0] DEF_HIGH   = WIDTH'(clk_div_pkg::DEF_HIGH)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [CH-1:0]                          en,
    input  logic                                   sync,
    input  logic                                   cfg_we,
    input  logic [clk_div_pkg::ch_sel_w(CH)-1:0]   cfg_ch,
    input  logic [WIDTH-1:0]                       cfg_period,
    input  logic [WIDTH-1:0]                       cfg_high,
    output logic [CH-1:0]                          cfg_pending,
    output logic [CH-1:0]                          div_out,
    output logic [CH-1:0]                          tick
);

    import clk_div_pkg::*;

    localparam int CH_SEL_W = ch_sel_w(CH);

    logic [CH-1:0] wr;

    // Selects beyond the last channel match no instance and are dropped.
    always_comb begin
        wr = '0;
        for (int i = 0; i < CH; i++) begin
            if (cfg_we && (cfg_ch == CH_SEL_W'(i))) begin
                wr[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        clk_div_channel #(
            .WIDTH      (WIDTH),
            .RST_PERIOD (DEF_PERIOD),
            .RST_HIGH   (DEF_HIGH)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en[g]),
            .sync      (sync),
            .wr        (wr[g]),
            .wr_period (cfg_period),
            .wr_high   (cfg_high),
            .div_out   (div_out[g]),
            .tick      (tick[g]),
            .pending   (cfg_pending[g])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: directed scenarios plus random traffic against a behavioural model.
module tb_clk_div_bank;

    localparam int               CH    = 3;
    localparam int               WIDTH = 8;
    localparam int               CW    = 2;
    localparam logic [WIDTH-1:0] DP    = 8'd9;
    localparam logic [WIDTH-1:0] DH    = 8'd4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CH-1:0]    en;
    logic             sync;
    logic             cfg_we;
    logic [CW-1:0]    cfg_ch;
    logic [WIDTH-1:0] cfg_period;
    logic [WIDTH-1:0] cfg_high;
    logic [CH-1:0]    cfg_pending;
    logic [CH-1:0]    div_out;
    logic [CH-1:0]    tick;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    clk_div_bank #(
        .CH         (CH),
        .WIDTH      (WIDTH),
        .DEF_PERIOD (DP),
        .DEF_HIGH   (DH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .sync        (sync),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_high    (cfg_high),
        .cfg_pending (cfg_pending),
        .div_out     (div_out),
        .tick        (tick)
    );

    typedef struct packed {
        logic [CH-1:0] div;
        logic [CH-1:0] tck;
        logic [CH-1:0] pend;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Model: each running channel sits at a position inside a period of (P+1) cycles.
    bit m_en  [CH];
    int m_pos [CH];
    int m_p   [CH];
    int m_h   [CH];
    int m_ps  [CH];
    int m_hs  [CH];
    bit m_pend[CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_en[c]   = 1'b0;
            m_pos[c]  = 0;
            m_p[c]    = int'(DP);
            m_h[c]    = int'(DH);
            m_ps[c]   = int'(DP);
            m_hs[c]   = int'(DH);
            m_pend[c] = 1'b0;
        end
    endtask

    task automatic model_step();
        exp_t e;
        bit   boundary;
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int c = 0; c < CH; c++) begin
                boundary = m_en[c] && (sync || m_pos[c] == m_p[c]);
                if (boundary) begin
                    m_pos[c] = 0;
                    if (m_pend[c]) begin
                        m_p[c]    = m_ps[c];
                        m_h[c]    = m_hs[c];
                        m_pend[c] = 1'b0;
                    end
                end else if (m_en[c]) begin
                    m_pos[c] = m_pos[c] + 1;
                end
                if (cfg_we && int'(cfg_ch) == c) begin
                    m_ps[c] = int'(cfg_period);
                    m_hs[c] = int'(cfg_high);
                    if (!m_en[c] || boundary) begin
                        m_p[c]    = m_ps[c];
                        m_h[c]    = m_hs[c];
                        m_pend[c] = 1'b0;
                    end else begin
                        m_pend[c] = 1'b1;
                    end
                end
                if (!en[c]) m_pos[c] = 0;
                m_en[c] = en[c];
            end
        end
        for (int c = 0; c < CH; c++) begin
            e.div[c]  = m_en[c] && (m_pos[c] < m_h[c]);
            e.tck[c]  = m_en[c] && (m_pos[c] == m_p[c]);
            e.pend[c] = m_pend[c];
        end
        exp_q.push_back(e);
    endtask

    // Drive during the low phase, let one edge happen, record the expectation, return at the next negedge.
    task automatic cyc(input logic [CH-1:0] e, input logic s, input logic we,
                       input logic [CW-1:0] ch, input int p, input int h);
        en         = e;
        sync       = s;
        cfg_we     = we;
        cfg_ch     = ch;
        cfg_period = WIDTH'(p);
        cfg_high   = WIDTH'(h);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input logic [CH-1:0] e);
        cyc(e, 1'b0, 1'b0, '0, 0, 0);
    endtask

    always begin
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("div_out",     32'(div_out),     32'(mon_e.div));
            check("tick",        32'(tick),        32'(mon_e.tck));
            check("cfg_pending", 32'(cfg_pending), 32'(mon_e.pend));
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit   found;
        int   tcnt;
        logic exp_pend [8];
        logic exp_div  [8];
        logic exp_tick [8];
        logic [CH-1:0] e_rand;

        rst_n = 1'b0;
        en = '0; sync = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_high = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_div_out",     32'(div_out),     32'(0));
        check("reset_tick",        32'(tick),        32'(0));
        check("reset_cfg_pending", 32'(cfg_pending), 32'(0));
        rst_n = 1'b1;

        // Basic pattern: ch0 P=3 H=2 written while idle, enabled at edge 0.
        cyc(3'b000, 1'b0, 1'b1, 2'd0, 3, 2);
        idle(3'b001);
        for (int k = 1; k <= 12; k++) begin
            check("basic_div0",  32'(div_out[0]), 32'(((k - 1) % 4) < 2));
            check("basic_tick0", 32'(tick[0]),    32'((k % 4) == 0));
            check("basic_ch12",  32'({div_out[2:1], tick[2:1]}), 32'(0));
            idle(3'b001);
        end

        // Shadow reload: write P=5 H=1 while cnt=1.
        idle(3'b001);
        cyc(3'b001, 1'b0, 1'b1, 2'd0, 5, 1);
        exp_pend = '{1, 1, 0, 0, 0, 0, 0, 0};
        exp_div  = '{0, 0, 1, 0, 0, 0, 0, 0};
        exp_tick = '{0, 1, 0, 0, 0, 0, 0, 1};
        for (int k = 0; k < 8; k++) begin
            check("reload_pending0", 32'(cfg_pending[0]), 32'(exp_pend[k]));
            check("reload_div0",     32'(div_out[0]),     32'(exp_div[k]));
            check("reload_tick0",    32'(tick[0]),        32'(exp_tick[k]));
            idle(3'b001);
        end

        // Wrap-edge bypass: write exactly in the tick cycle.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (tick[0]) found = 1'b1;
            else idle(3'b001);
        end
        check("bypass_found_tick", 32'(found), 32'(1));
        cyc(3'b001, 1'b0, 1'b1, 2'd0, 3, 2);
        for (int k = 0; k < 4; k++) begin
            check("bypass_pending0", 32'(cfg_pending[0]), 32'(0));
            check("bypass_div0",     32'(div_out[0]),     32'(k < 2));
            check("bypass_tick0",    32'(tick[0]),        32'(k == 3));
            idle(3'b001);
        end

        // Sync alignment: ch1 P=7 H=3, bring ch0 to cnt=2 and ch1 to cnt=5, then sync.
        cyc(3'b001, 1'b0, 1'b1, 2'd1, 7, 3);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (m_pos[0] == 0) found = 1'b1;
            else idle(3'b001);
        end
        check("sync_align_ch0", 32'(found), 32'(1));
        idle(3'b011);
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            if (m_pos[0] == 2 && m_pos[1] == 5) found = 1'b1;
            else idle(3'b011);
        end
        check("sync_reach_2_5", 32'(found), 32'(1));
        cyc(3'b011, 1'b1, 1'b0, 2'd0, 0, 0);
        check("sync_div_both_high", 32'(div_out[1:0]), 32'(2'b11));
        check("sync_tick_low",      32'(tick[1:0]),    32'(0));

        // Boundaries on ch2: H=0, H>P, P=0, then an out-of-range select.
        cyc(3'b011, 1'b0, 1'b1, 2'd2, 3, 0);
        idle(3'b111);
        for (int k = 0; k < 8; k++) begin
            check("h0_div2_low", 32'(div_out[2]), 32'(0));
            idle(3'b111);
        end
        cyc(3'b111, 1'b0, 1'b1, 2'd2, 3, 9);
        for (int k = 0; k < 6; k++) idle(3'b111);
        for (int k = 0; k < 8; k++) begin
            check("hgtp_div2_high", 32'(div_out[2]), 32'(1));
            idle(3'b111);
        end
        cyc(3'b111, 1'b0, 1'b1, 2'd2, 0, 1);
        for (int k = 0; k < 5; k++) idle(3'b111);
        for (int k = 0; k < 6; k++) begin
            check("p0_tick2_every", 32'(tick[2]), 32'(1));
            idle(3'b111);
        end
        cyc(3'b111, 1'b0, 1'b1, 2'd3, 1, 1);
        for (int k = 0; k < 3; k++) begin
            check("badch_tick2_kept", 32'(tick[2]),     32'(1));
            check("badch_no_pending", 32'(cfg_pending), 32'(0));
            idle(3'b111);
        end

        // Random traffic.
        e_rand = 3'b111;
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 19) == 0) e_rand[c] = ~e_rand[c];
            end
            cyc(e_rand, ($urandom_range(0, 24) == 0), ($urandom_range(0, 4) == 0),
                CW'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 9)));
        end

        // Async reset mid-period with ch0 forced high (H>P).
        idle(3'b000);
        cyc(3'b000, 1'b0, 1'b1, 2'd0, 7, 9);
        idle(3'b001);
        @(posedge clk);
        #2;
        check("prereset_div0_high", 32'(div_out[0]), 32'(1));
        #1;
        rst_n = 1'b0;
        #1;
        check("async_div_out_low", 32'(div_out),     32'(0));
        check("async_tick_low",    32'(tick),        32'(0));
        check("async_pending_low", 32'(cfg_pending), 32'(0));
        model_reset();
        @(negedge clk);
        cyc(3'b111, 1'b1, 1'b1, 2'd1, 2, 1);
        cyc(3'b111, 1'b1, 1'b0, 2'd0, 0, 0);
        rst_n = 1'b1;
        idle(3'b000);
        check("release_pending_low", 32'(cfg_pending), 32'(0));

        // Defaults restored: period DP+1 = 10 cycles, so two ticks in cycles 1..21.
        idle(3'b001);
        tcnt = 0;
        for (int k = 1; k <= 21; k++) begin
            if (tick[0]) tcnt++;
            idle(3'b001);
        end
        check("default_tick_count", 32'(tcnt), 32'(2));

        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Multi-channel programmable clock divider. Successor to the single-channel toggle divider.
- Each channel has its own period and high-time, so duty cycle is arbitrary, not fixed at 50%.
- Adds per-channel enable, shadowed glitch-free reconfiguration, a common phase-sync input and a per-period tick strobe.
- Sits between the board clock and slow peripherals (display scan, UART baud, LED blink). All outputs are synchronous to clk.

Parameters:
- CH, 4: number of independent channels (1..16).
- WIDTH, 32: counter/config width in bits.
- DEF_PERIOD, 32'd49_999_999: reset value of the active and shadow period (P) for all channels.
- DEF_HIGH, 32'd25_000_000: reset value of the active and shadow high-time (H) for all channels.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  CH  per-channel enable, level.
- sync  in  1  single-cycle pulse; restarts all enabled channels in phase.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  $clog2(CH) (min 1)  target channel of the write.
- cfg_period  in  WIDTH  new P; period = P+1 clk cycles.
- cfg_high  in  WIDTH  new H; output high for H cycles per period.
- cfg_pending  out  CH  shadow written but not yet applied.
- div_out  out  CH  divided clock per channel.
- tick  out  CH  one-cycle strobe in the last cycle of each period.

Behaviour:
- Reset (async assert, sync-safe release):
  - cnt=0, en_q=0.
  - Active and shadow P/H = DEF_*.
  - div_out=0, tick=0, cfg_pending=0.
- Per-channel registered state: cnt[WIDTH], en_q, P_act, H_act, P_sh, H_sh, pend.
- All outputs are decoded from registered state only (flop outputs, no combinational path from inputs):
  - div_out = en_q && (cnt < H_act).
  - tick = en_q && (cnt == P_act).
- Duty edge cases:
  - H=0: div_out constant 0.
  - H>P: div_out constant 1 while enabled.
  - P=0: tick high every cycle.
- Enable:
  - en_q <= en each edge.
  - While en_q=0: cnt held 0, outputs 0.
  - en rising sampled at edge k: channel active from cycle k+1 with cnt=0, so the first period is full length.
  - en falling at edge k: outputs 0 from cycle k+1; cnt reset to 0.
- Counting, while en_q=1 each edge:
  - If sync or cnt==P_act: cnt<=0, and if pend then P_act<=P_sh, H_act<=H_sh, pend<=0.
  - Else cnt<=cnt+1. Arithmetic is unsigned, WIDTH bits; cnt never exceeds P_act, so no wrap-around.
- Config write (cfg_we=1, cfg_ch<CH):
  - P_sh/H_sh of that channel <= inputs; pend<=1.
  - If the channel is disabled (en_q=0): also copy into active in the same edge; pend stays 0.
  - Write at the same edge as that channel's wrap or sync: written values go straight to active (bypass); pend=0.
  - Back-to-back writes before a wrap: last write wins.
  - cfg_ch>=CH: write ignored, no state change.
- sync:
  - Affects only enabled channels; disabled channels ignore it.
  - sync and wrap on the same edge behave identically (single restart, no double count).
  - sync during reset is ignored.
- cfg_pending = pend vector, registered.
- Reset asserted mid-period: all outputs to 0 immediately (async); configuration reverts to DEF_*.
- Compatibility: P=2N+1, H=N+1 reproduces the legacy toggle divider with init value N (50% duty, period 2N+2).

Decomposition:
- Package clk_div_pkg holds:
  - Default constants DEF_PERIOD and DEF_HIGH.
  - Width-derived localparam for cfg_ch.
- Sub-module clk_div_channel holds one channel's cnt, en_q, active/shadow regs, pend, and decode.
  - Its inputs: en, sync, a local write strobe, cfg data.
  - clk_div_bank only generates CH instances and decodes cfg_ch into per-channel write strobes.

Test Plan:
- Basic pattern (CH=2, WIDTH=8, ch0 P=3 H=2, en=01 at edge 0):
  - From cycle 1, div_out[0] = 1,1,0,0 repeating.
  - tick[0] high at cycles 4,8,12.
  - ch1 outputs stay 0.
- Shadow reload: while running ch0 P=3 H=2, write P=5 H=1 at cycle 2:
  - cfg_pending[0]=1 during cycles 3..4.
  - New 6-cycle pattern 1,0,0,0,0,0 from cycle 5; pending clears at the same edge.
- Wrap-edge bypass: write at the exact cycle tick[0]=1 -> new values active next cycle; cfg_pending never rises.
- Sync alignment: ch0 P=3, ch1 P=7, both enabled, ch0 cnt=2 and ch1 cnt=5 -> pulse sync -> next cycle both cnt=0, both div_out high (H>0).
- Boundaries:
  - H=0 -> div_out stuck 0.
  - H=9 with P=3 -> stuck 1.
  - P=0 -> tick every cycle.
  - cfg_ch=3 with CH=2 -> no change.
- Async reset mid-period: drop rst_n between edges -> div_out/tick 0 immediately, before the next edge. After release, defaults restored and cfg_pending=0.
